// File: rtl/ootx_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ootx_sched_pkg : shared states, defaults and helpers for the scheduler   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package ootx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_PROBE   = 3'd2,
    ST_DWELL   = 3'd3,
    ST_ADVANCE = 3'd4
  } sched_state_t;

  // 50 ms and 8 s at a 50 MHz system clock.
  localparam int unsigned DEFAULT_PROBE_CYCLES = 32'd2_500_000;
  localparam int unsigned DEFAULT_DWELL_CYCLES = 32'd400_000_000;

  localparam int unsigned LH0 = 0;
  localparam int unsigned LH1 = 1;
  localparam logic [1:0]  LH_BOTH = 2'b11;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sensor_edge_detect : 2-FF synchronizer plus rising-edge detector         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sensor_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic line_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/ootx_sensor_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ootx_sensor_scheduler : round-robin photodiode channel scheduler for the |
// | OOTX decoder. Optional probing: OOTX_SCHED_ACTIVITY_SKIP_EN. Rev 1.0     |
// +--------------------------------------------------------------------------+
module ootx_sensor_scheduler
  import ootx_sched_pkg::*;
#(
  parameter int unsigned NUMBER_OF_SENSORS = 8,
  parameter int unsigned PROBE_CYCLES      = DEFAULT_PROBE_CYCLES,
  parameter int unsigned DWELL_CYCLES      = DEFAULT_DWELL_CYCLES
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUMBER_OF_SENSORS-1:0] sensor_signals,
  input  logic [1:0]                   sync,
  output logic [7:0]                   sensor_select,
  output logic                         decoder_clear,
  output logic [1:0]                   lh_seen,
  output logic                         scan_done,
  output logic                         timeout
);

  localparam logic [7:0]  LAST_SEL   = 8'(NUMBER_OF_SENSORS - 1);
  localparam logic [31:0] DWELL_LAST = DWELL_CYCLES - 32'd1;

  sched_state_t state_q, state_d;
  logic [7:0]   sensor_select_q, sensor_select_d;
  logic [1:0]   lh_seen_q, lh_seen_d;
  logic         decoder_clear_q, decoder_clear_d;
  logic         scan_done_q, scan_done_d;
  logic         timeout_q, timeout_d;
  logic [31:0]  dwell_cnt_q;
  logic         dwell_expired;
  logic [1:0]   lh_merged;

`ifdef OOTX_SCHED_ACTIVITY_SKIP_EN
  localparam logic [31:0] PROBE_LAST = PROBE_CYCLES - 32'd1;

  logic [255:0] lines_padded;
  logic         selected_line;
  logic         probe_rise;
  logic [31:0]  probe_cnt_q;
  logic         probe_expired;

  // Padding to the full 8-bit select range keeps the mux index width exact.
  assign lines_padded  = 256'(sensor_signals);
  assign selected_line = lines_padded[sensor_select_q];

  sensor_edge_detect u_edge_detect (
    .clock  (clock),
    .reset  (reset),
    .line_i (selected_line),
    .rise_o (probe_rise)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      probe_cnt_q <= 32'd0;
    end else if (state_d != state_q) begin
      probe_cnt_q <= 32'd0;
    end else if (state_q == ST_PROBE) begin
      probe_cnt_q <= sat_inc(probe_cnt_q);
    end
  end

  assign probe_expired = (probe_cnt_q >= PROBE_LAST);
`else
  logic unused_probe_cfg;
  assign unused_probe_cfg = ^{sensor_signals, PROBE_CYCLES};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dwell_cnt_q <= 32'd0;
    end else if (state_d != state_q) begin
      dwell_cnt_q <= 32'd0;
    end else if (state_q == ST_DWELL) begin
      dwell_cnt_q <= sat_inc(dwell_cnt_q);
    end
  end

  assign dwell_expired = (dwell_cnt_q >= DWELL_LAST);

  // A sync bit in the expiry cycle is merged before the timeout decision.
  assign lh_merged[LH0] = lh_seen_q[LH0] | sync[LH0];
  assign lh_merged[LH1] = lh_seen_q[LH1] | sync[LH1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      sensor_select_q <= 8'd0;
      lh_seen_q       <= 2'b00;
      decoder_clear_q <= 1'b0;
      scan_done_q     <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      sensor_select_q <= sensor_select_d;
      lh_seen_q       <= lh_seen_d;
      decoder_clear_q <= decoder_clear_d;
      scan_done_q     <= scan_done_d;
      timeout_q       <= timeout_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    sensor_select_d = sensor_select_q;
    lh_seen_d       = lh_seen_q;
    decoder_clear_d = 1'b0;
    scan_done_d     = 1'b0;
    timeout_d       = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CLEAR;
        end
        ST_CLEAR: begin
`ifdef OOTX_SCHED_ACTIVITY_SKIP_EN
          state_d = ST_PROBE;
`else
          state_d = ST_DWELL;
`endif
        end
`ifdef OOTX_SCHED_ACTIVITY_SKIP_EN
        ST_PROBE: begin
          if (probe_rise) begin
            state_d = ST_DWELL;
          end else if (probe_expired) begin
            state_d = ST_ADVANCE;
          end
        end
`endif
        ST_DWELL: begin
          lh_seen_d = lh_merged;
          if (lh_seen_q == LH_BOTH) begin
            state_d = ST_ADVANCE;
          end else if (dwell_expired) begin
            state_d   = ST_ADVANCE;
            timeout_d = (lh_merged != LH_BOTH);
          end
        end
        ST_ADVANCE: begin
          state_d = ST_CLEAR;
          if (sensor_select_q >= LAST_SEL) begin
            sensor_select_d = 8'd0;
            scan_done_d     = 1'b1;
          end else begin
            sensor_select_d = sensor_select_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Registered so decoder_clear and the zeroed flags coincide with CLEAR.
    if (state_d == ST_CLEAR) begin
      decoder_clear_d = 1'b1;
      lh_seen_d       = 2'b00;
    end
  end

  assign sensor_select = sensor_select_q;
  assign decoder_clear = decoder_clear_q;
  assign lh_seen       = lh_seen_q;
  assign scan_done     = scan_done_q;
  assign timeout       = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ootx_sensor_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ootx_sensor_scheduler : randomized scoreboard bench for the scheduler |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ootx_sensor_scheduler;

  localparam int unsigned N      = 4;
  localparam int unsigned PROBE  = 64;
  localparam int unsigned DWELL  = 1000;
  localparam int          VISITS = 12;

  typedef struct {
    bit         clr;
    bit         to;
    bit         sd;
    logic [7:0] sel;
    logic [1:0] lh;
    longint     cyc;
  } ev_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] sensor_signals;
  logic [1:0]   sync;
  logic [7:0]   sensor_select;
  logic         decoder_clear;
  logic [1:0]   lh_seen;
  logic         scan_done;
  logic         timeout;

  ev_t    exp_q[$];
  ev_t    mon_e;
  longint cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  int     cur_ch = 0;
  bit     aborted = 1'b0;

  ootx_sensor_scheduler #(
    .NUMBER_OF_SENSORS (N),
    .PROBE_CYCLES      (PROBE),
    .DWELL_CYCLES      (DWELL)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .sensor_signals (sensor_signals),
    .sync           (sync),
    .sensor_select  (sensor_select),
    .decoder_clear  (decoder_clear),
    .lh_seen        (lh_seen),
    .scan_done      (scan_done),
    .timeout        (timeout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit clr, input bit to, input bit sd, input int sel,
                         input logic [1:0] lh, input longint at);
    ev_t e;
    e.clr = clr; e.to = to; e.sd = sd; e.sel = 8'(sel); e.lh = lh; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse the DUT presents is matched against the next expectation.
  always @(negedge clock) begin
    if (decoder_clear || timeout || scan_done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got clr/to/sd=%b%b%b sel=%0d expected none (cycle %0d)",
                 decoder_clear, timeout, scan_done, sensor_select, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_pulses", 64'({decoder_clear, timeout, scan_done}), 64'({mon_e.clr, mon_e.to, mon_e.sd}));
        chk("ev_select", 64'(sensor_select), 64'(mon_e.sel));
        chk("ev_lh_seen", 64'(lh_seen), 64'(mon_e.lh));
        chk("ev_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic wait_clear(output longint c0, output bit ok);
    ok = 1'b0;
    c0 = 0;
    for (int i = 0; i < int'(DWELL + PROBE) + 50; i++) begin
      if (!ok) begin
        @(negedge clock);
        if (decoder_clear) begin
          ok = 1'b1;
          c0 = cyc;
        end
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_clear: got no decoder_clear expected one within %0d cycles", DWELL + PROBE + 50);
    end
  endtask

  // Returns the first dwell cycle; with probing the channel line is raised first.
  task automatic enter_dwell(input int ch, input longint c0, output longint ds);
`ifdef OOTX_SCHED_ACTIVITY_SKIP_EN
    int p;
    p = int'($urandom_range(0, PROBE - 10));
    for (int i = 0; i <= p; i++) begin
      @(posedge clock); #1;
    end
    sensor_signals[ch] = 1'b1;
    ds = c0 + 4 + longint'(p);
`else
    ds = c0 + 1;
    if (ch < 0) ds = 0;
`endif
  endtask

  task automatic run_visit(input int scen, output bit ok);
    longint     c0, ds, adv;
    logic [1:0] plan [DWELL];
    logic [1:0] seen;
    logic [31:0] r;
    int         a, tc, len, nxt;
    wait_clear(c0, ok);
    if (ok) begin
      nxt = (cur_ch + 1) % N;
`ifndef OOTX_SCHED_ACTIVITY_SKIP_EN
      r = $urandom;
      sensor_signals = r[N-1:0];
`endif
      if (scen == 7) begin
        // Silent channel: probing gives up, no timeout, straight to the next channel.
        push_ev(1'b1, 1'b0, cur_ch == N - 1, nxt, 2'b00, c0 + 2 + PROBE);
      end else begin
        for (int t = 0; t < DWELL; t++) plan[t] = 2'b00;
        a = int'($urandom_range(0, 300));
        case (scen)
          0: begin plan[a] = 2'b01; plan[a + 100] = 2'b10; end
          1: begin plan[a] = 2'b01; plan[DWELL - 1] = 2'b01; end
          2: begin plan[a] = 2'b01; plan[DWELL - 1] = 2'b10; end
          3: begin end
          4: begin plan[a] = 2'b11; end
          5: begin plan[a] = 2'b10; plan[DWELL - 2] = 2'b01; end
          default: begin plan[a] = 2'b10; plan[a + 7] = 2'b10; end
        endcase
        seen = 2'b00;
        tc = -1;
        for (int t = 0; t < DWELL; t++) begin
          seen = seen | plan[t];
          if (seen == 2'b11 && tc < 0) tc = t;
        end
        len = (tc < 0) ? DWELL : ((tc + 2 < DWELL) ? tc + 2 : DWELL);
        enter_dwell(cur_ch, c0, ds);
        adv = ds + longint'(len);
        if (tc < 0) push_ev(1'b0, 1'b1, 1'b0, cur_ch, seen, adv);
        push_ev(1'b1, 1'b0, cur_ch == N - 1, nxt, 2'b00, adv + 1);
        while (cyc + 1 < ds) begin @(posedge clock); #1; end
        for (int t = 0; t < len; t++) begin
          @(posedge clock); #1;
          sync = plan[t];
`ifdef OOTX_SCHED_ACTIVITY_SKIP_EN
          if (t == 0) sensor_signals[cur_ch] = 1'b0;
`endif
          if (tc >= 0 && t == tc + 1) begin
            @(negedge clock);
            chk("lh_seen_complete", 64'(lh_seen), 64'(2'b11));
          end
        end
        @(posedge clock); #1;
        sync = 2'b00;
      end
      cur_ch = nxt;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no end of run expected $finish before 900000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint c0, ds;
    bit     ok;
    int     scen;
    reset = 1'b1;
    enable = 1'b0;
    sync = 2'b00;
    sensor_signals = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_select", 64'(sensor_select), 64'd0);
    chk("reset_clear", 64'(decoder_clear), 64'd0);
    chk("reset_lh_seen", 64'(lh_seen), 64'd0);
    chk("reset_scan_done", 64'(scan_done), 64'd0);
    chk("reset_timeout", 64'(timeout), 64'd0);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("idle_select", 64'(sensor_select), 64'd0);
    enable = 1'b1;
    push_ev(1'b1, 1'b0, 1'b0, 0, 2'b00, cyc + 1);

    for (int v = 0; v < VISITS; v++) begin
      if (!aborted) begin
`ifdef OOTX_SCHED_ACTIVITY_SKIP_EN
        scen = (v < 8) ? v : int'($urandom_range(0, 7));
`else
        scen = (v < 7) ? v : int'($urandom_range(0, 6));
`endif
        run_visit(scen, ok);
        if (!ok) aborted = 1'b1;
      end
    end

    if (!aborted) begin
      // Enable dropped mid-dwell: flags and channel hold, restart on the same channel.
      wait_clear(c0, ok);
      if (ok) begin
        enter_dwell(cur_ch, c0, ds);
        while (cyc + 1 < ds) begin @(posedge clock); #1; end
        @(posedge clock); #1;
        sync = 2'b01;
`ifdef OOTX_SCHED_ACTIVITY_SKIP_EN
        sensor_signals[cur_ch] = 1'b0;
`endif
        @(posedge clock); #1;
        sync = 2'b00;
        repeat (10) @(posedge clock);
        #1;
        enable = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk("hold_select", 64'(sensor_select), 64'(cur_ch));
        chk("hold_lh_seen", 64'(lh_seen), 64'(2'b01));
        @(posedge clock); #1;
        enable = 1'b1;
        push_ev(1'b1, 1'b0, 1'b0, cur_ch, 2'b00, cyc + 1);
        wait_clear(c0, ok);
      end
      if (ok) begin
        // Reset mid-dwell discards the flags and restarts the scan at channel 0.
        enter_dwell(cur_ch, c0, ds);
        while (cyc + 1 < ds) begin @(posedge clock); #1; end
        @(posedge clock); #1;
        sync = 2'b10;
`ifdef OOTX_SCHED_ACTIVITY_SKIP_EN
        sensor_signals[cur_ch] = 1'b0;
`endif
        @(posedge clock); #1;
        sync = 2'b00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("pre_reset_lh_seen", 64'(lh_seen), 64'(2'b10));
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("async_reset_select", 64'(sensor_select), 64'd0);
        chk("async_reset_lh_seen", 64'(lh_seen), 64'd0);
        chk("async_reset_pulses", 64'({decoder_clear, scan_done, timeout}), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cur_ch = 0;
        push_ev(1'b1, 1'b0, 1'b0, 0, 2'b00, cyc + 1);
        wait_clear(c0, ok);
        @(posedge clock); #1;
        enable = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("restart_select", 64'(sensor_select), 64'd0);
      end
      if (!ok) aborted = 1'b1;
    end

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
